// File: rtl/rmt_pkg.sv
// Shared definitions for the RMT pipeline: default PHV geometry, segment math
// and the PHV buffer phase encoding.
package rmt_pkg;

    localparam int PHV_WIDTH_DEFAULT = 1124;
    localparam int SEG_WIDTH_DEFAULT = 512;

    // Number of SEG_WIDTH columns needed to hold a PHV of the given width.
    function automatic int seg_num(input int width, input int seg_width);
        return (width + seg_width - 1) / seg_width;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } buf_phase_e;

endpackage

// File: rtl/rmt_phv_seg_ram.sv
// One storage column of the PHV buffer: WIDTH x DEPTH, one write port and one
// asynchronous read port. Contents are not reset; validity is tracked by pointers.
module rmt_phv_seg_ram #(
    parameter int WIDTH = 513,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rmt_phv_buffer.sv
// First-word-fall-through PHV buffer between the last MA stage and the deparser.
// Optional per-segment even parity is enabled with `define RMT_PHV_BUF_PARITY_EN.
module rmt_phv_buffer
    import rmt_pkg::*;
#(
    parameter int PHV_WIDTH = PHV_WIDTH_DEFAULT,
    parameter int SEG_WIDTH = SEG_WIDTH_DEFAULT,
    parameter int DEPTH     = 16,
    parameter int NF_MARGIN = 4,
    parameter int CNT_WIDTH = 32,
    localparam int AW       = $clog2(DEPTH),
    localparam int OW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [PHV_WIDTH-1:0] phv_in,
    input  logic                 phv_in_valid,
    output logic [PHV_WIDTH-1:0] phv_out,
    input  logic                 phv_rd_en,
    output logic                 empty,
    output logic                 full,
    output logic                 nearly_full,
    output logic [OW-1:0]        occupancy,
    output logic [CNT_WIDTH-1:0] drop_cnt,
    output logic                 parity_err,
    output buf_phase_e           phase
);

    localparam int SEG_NUM = seg_num(PHV_WIDTH, SEG_WIDTH);
    localparam int TOT     = SEG_NUM * SEG_WIDTH;
`ifdef RMT_PHV_BUF_PARITY_EN
    localparam int RW      = SEG_WIDTH + 1;
`else
    localparam int RW      = SEG_WIDTH;
`endif

    logic [AW-1:0]        wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [OW-1:0]        occ_q, occ_next;
    logic                 empty_q, full_q, nf_q;
    logic [CNT_WIDTH-1:0] drop_q;
    logic                 rd_acc, wr_acc, drop;
    logic                 head_load, head_src_in;
    logic [TOT-1:0]       in_pad;
    logic [TOT-1:0]       head_flat;
    logic [RW-1:0]        ram_wr [SEG_NUM];
    logic [RW-1:0]        ram_rd [SEG_NUM];
    logic [RW-1:0]        head_q [SEG_NUM];
    buf_phase_e           phase_q, phase_next;

    // Handshake: rd_acc uses the registered empty flag, so a write into an
    // empty buffer is never popped in the same cycle.
    always_comb begin
        rd_acc = phv_rd_en & ~empty_q;
        wr_acc = phv_in_valid & (~full_q | rd_acc);
        drop   = phv_in_valid & full_q & ~rd_acc;
    end

    always_comb begin
        occ_next = occ_q;
        case ({wr_acc, rd_acc})
            2'b10:   occ_next = occ_q + 1'b1;
            2'b01:   occ_next = occ_q - 1'b1;
            default: occ_next = occ_q;
        endcase
    end

    always_comb begin
        in_pad                = '0;
        in_pad[PHV_WIDTH-1:0] = phv_in;
    end

    assign rd_ptr_nxt = rd_ptr + 1'b1;

    for (genvar s = 0; s < SEG_NUM; s++) begin : g_seg
        logic [SEG_WIDTH-1:0] seg_in;
        assign seg_in = in_pad[s*SEG_WIDTH +: SEG_WIDTH];
`ifdef RMT_PHV_BUF_PARITY_EN
        assign ram_wr[s] = {^seg_in, seg_in};
`else
        assign ram_wr[s] = seg_in;
`endif
        rmt_phv_seg_ram #(
            .WIDTH (RW),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk     (clk),
            .wr_en   (wr_acc),
            .wr_addr (wr_ptr),
            .wr_data (ram_wr[s]),
            .rd_addr (rd_ptr_nxt),
            .rd_data (ram_rd[s])
        );
        assign head_flat[s*SEG_WIDTH +: SEG_WIDTH] = head_q[s][SEG_WIDTH-1:0];
    end

    if (TOT > PHV_WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^head_flat[TOT-1:PHV_WIDTH];
    end

    // The head register is refilled from the entry behind the head on a pop,
    // or straight from phv_in when that PHV becomes the new head this cycle.
    always_comb begin
        head_load   = 1'b0;
        head_src_in = 1'b0;
        if (rd_acc) begin
            if (occ_q > OW'(1)) begin
                head_load = 1'b1;
            end else if (wr_acc) begin
                head_load   = 1'b1;
                head_src_in = 1'b1;
            end
        end else if (wr_acc && empty_q) begin
            head_load   = 1'b1;
            head_src_in = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            for (int s = 0; s < SEG_NUM; s++) head_q[s] <= '0;
        end else if (head_load) begin
            for (int s = 0; s < SEG_NUM; s++) begin
                head_q[s] <= head_src_in ? ram_wr[s] : ram_rd[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            nf_q    <= 1'b0;
            drop_q  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr_nxt;
            occ_q   <= occ_next;
            empty_q <= (occ_next == '0);
            full_q  <= (occ_next == OW'(DEPTH));
            nf_q    <= (occ_next >= OW'(DEPTH - NF_MARGIN));
            if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) phase_q <= IDLE;
        else          phase_q <= phase_next;
    end

    always_comb begin
        phase_next = phase_q;
        case (phase_q)
            IDLE:    if (occ_next != '0) phase_next = ACTIVE;
            ACTIVE: begin
                if (occ_next == '0)               phase_next = IDLE;
                else if (occ_next == OW'(DEPTH))  phase_next = FULL;
            end
            FULL:    if (occ_next != OW'(DEPTH)) phase_next = ACTIVE;
            default: phase_next = IDLE;
        endcase
    end

`ifdef RMT_PHV_BUF_PARITY_EN
    logic par_mis, par_err_q;

    // Data plus its stored even-parity bit must XOR to zero in every segment.
    always_comb begin
        par_mis = 1'b0;
        for (int s = 0; s < SEG_NUM; s++) par_mis = par_mis | (^head_q[s]);
    end

    always_ff @(posedge clk) begin
        if (!aresetn)                par_err_q <= 1'b0;
        else if (rd_acc && par_mis)  par_err_q <= 1'b1;
    end

    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign phv_out     = head_flat[PHV_WIDTH-1:0];
    assign empty       = empty_q;
    assign full        = full_q;
    assign nearly_full = nf_q;
    assign occupancy   = occ_q;
    assign drop_cnt    = drop_q;
    assign phase       = phase_q;

endmodule

// File: tb/tb_rmt_phv_buffer.sv
// Randomized bench for rmt_phv_buffer against a queue-based reference model.
// The parity scenario is included when RMT_PHV_BUF_PARITY_EN is defined.
module tb_rmt_phv_buffer;
    import rmt_pkg::*;

    localparam int W      = 1124;
    localparam int DEPTH  = 16;
    localparam int NF_MAR = 4;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [W-1:0]  phv_in = '0;
    logic          phv_in_valid = 1'b0;
    logic [W-1:0]  phv_out;
    logic          phv_rd_en = 1'b0;
    logic          empty, full, nearly_full, parity_err;
    logic [4:0]    occupancy;
    logic [31:0]   drop_cnt;
    buf_phase_e    phase;

    logic [W-1:0]  exp_q[$];
    int unsigned   exp_drop;
    int            n_pass, n_total;

    always #5 clk = ~clk;

    rmt_phv_buffer #(
        .PHV_WIDTH (W),
        .SEG_WIDTH (512),
        .DEPTH     (DEPTH),
        .NF_MARGIN (NF_MAR),
        .CNT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .phv_in       (phv_in),
        .phv_in_valid (phv_in_valid),
        .phv_out      (phv_out),
        .phv_rd_en    (phv_rd_en),
        .empty        (empty),
        .full         (full),
        .nearly_full  (nearly_full),
        .occupancy    (occupancy),
        .drop_cnt     (drop_cnt),
        .parity_err   (parity_err),
        .phase        (phase)
    );

    function automatic logic [W-1:0] rand_phv();
        logic [1151:0] t;
        for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom;
        return t[W-1:0];
    endfunction

    function automatic buf_phase_e model_phase(input int n);
        if (n == 0)     return IDLE;
        if (n == DEPTH) return FULL;
        return ACTIVE;
    endfunction

    // Driver: one clock cycle of stimulus, model updated at the active edge,
    // outputs left for the caller to sample on the following falling edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        bit m_rd, m_wr;
        phv_in       = d;
        phv_in_valid = v;
        phv_rd_en    = r;
        @(posedge clk);
        m_rd = r && (exp_q.size() > 0);
        m_wr = v && ((exp_q.size() < DEPTH) || m_rd);
        if (m_rd) void'(exp_q.pop_front());
        if (m_wr) exp_q.push_back(d);
        if (v && !m_wr) exp_drop++;
        @(negedge clk);
        phv_in_valid = 1'b0;
        phv_rd_en    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        aresetn = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        exp_q.delete();
        exp_drop = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty got=%b want=1", empty); else n_pass++;
        n_total++; if (full !== 1'b0 || nearly_full !== 1'b0) $display("FAIL reset_flags full=%b nf=%b want=0/0", full, nearly_full); else n_pass++;
        n_total++; if (occupancy !== 5'd0 || drop_cnt !== 32'd0) $display("FAIL reset_counts occ=%0d drop=%0d want=0/0", occupancy, drop_cnt); else n_pass++;
        n_total++; if (phv_out !== '0) $display("FAIL reset_phv_out got=%h want=0", phv_out[127:0]); else n_pass++;
        n_total++; if (parity_err !== 1'b0 || phase !== IDLE) $display("FAIL reset_misc perr=%b phase=%0d want=0/0", parity_err, phase); else n_pass++;
    endtask

    task automatic test_single();
        logic [W-1:0] pat;
        logic [7:0]   b = 8'hA5;
        for (int i = 0; i < W; i++) pat[i] = b[i % 8];
        step(1'b1, pat, 1'b0);
        n_total++; if (empty !== 1'b0) $display("FAIL single_empty got=%b want=0", empty); else n_pass++;
        n_total++; if (phv_out !== pat) $display("FAIL single_data got=%h want=%h (low bits)", phv_out[127:0], pat[127:0]); else n_pass++;
        n_total++; if (occupancy !== 5'd1 || phase !== ACTIVE) $display("FAIL single_occ occ=%0d phase=%0d want=1/1", occupancy, phase); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_total++; if (empty !== 1'b1 || occupancy !== 5'd0) $display("FAIL single_pop empty=%b occ=%0d want=1/0", empty, occupancy); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, rand_phv(), 1'b0);
            n_total++;
            if (nearly_full !== (exp_q.size() >= DEPTH - NF_MAR))
                $display("FAIL fill_nf n=%0d got=%b want=%b", exp_q.size(), nearly_full, exp_q.size() >= DEPTH - NF_MAR);
            else n_pass++;
        end
        n_total++; if (nearly_full !== 1'b1 || full !== 1'b0) $display("FAIL fill12 nf=%b full=%b want=1/0", nearly_full, full); else n_pass++;
        for (int i = 0; i < 4; i++) step(1'b1, rand_phv(), 1'b0);
        n_total++; if (full !== 1'b1 || occupancy !== 5'd16) $display("FAIL fill16 full=%b occ=%0d want=1/16", full, occupancy); else n_pass++;
        n_total++; if (phase !== FULL) $display("FAIL fill_phase got=%0d want=%0d", phase, FULL); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) step(1'b1, rand_phv(), 1'b0);
        n_total++; if (drop_cnt !== exp_drop) $display("FAIL ovf_drop got=%0d want=%0d", drop_cnt, exp_drop); else n_pass++;
        n_total++; if (occupancy !== 5'd16) $display("FAIL ovf_occ got=%0d want=16", occupancy); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            n_total++;
            if (phv_out !== exp_q[0]) $display("FAIL drain_data idx=%0d got=%h want=%h", i, phv_out[127:0], exp_q[0][127:0]);
            else n_pass++;
            step(1'b0, '0, 1'b1);
        end
        n_total++; if (empty !== 1'b1 || occupancy !== 5'd0) $display("FAIL drain_end empty=%b occ=%0d want=1/0", empty, occupancy); else n_pass++;
    endtask

    task automatic test_full_rw();
        int unsigned d0;
        while (exp_q.size() < DEPTH) step(1'b1, rand_phv(), 1'b0);
        d0 = exp_drop;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (phv_out !== exp_q[0]) $display("FAIL fullrw_data i=%0d got=%h want=%h", i, phv_out[127:0], exp_q[0][127:0]);
            else n_pass++;
            step(1'b1, rand_phv(), 1'b1);
            n_total++;
            if (occupancy !== 5'd16 || drop_cnt !== d0) $display("FAIL fullrw_occ i=%0d occ=%0d drop=%0d want=16/%0d", i, occupancy, drop_cnt, d0);
            else n_pass++;
        end
        while (exp_q.size() > 0) begin
            n_total++;
            if (phv_out !== exp_q[0]) $display("FAIL fullrw_drain got=%h want=%h", phv_out[127:0], exp_q[0][127:0]);
            else n_pass++;
            step(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_wrap();
        int errs = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, rand_phv(), 1'b0);
            if (phv_out !== exp_q[0] || occupancy !== 5'd1) errs++;
            step(1'b0, '0, 1'b1);
            if (empty !== 1'b1) errs++;
        end
        n_total++; if (errs != 0) $display("FAIL wrap_pairs errors=%0d want=0", errs); else n_pass++;
        n_total++; if (drop_cnt !== exp_drop) $display("FAIL wrap_drop got=%0d want=%0d", drop_cnt, exp_drop); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_total++; if (occupancy !== 5'd0 || empty !== 1'b1) $display("FAIL empty_pop occ=%0d empty=%b want=0/1", occupancy, empty); else n_pass++;
        step(1'b1, rand_phv(), 1'b1);
        n_total++; if (occupancy !== 5'd1 || phv_out !== exp_q[0]) $display("FAIL wr_rd_empty occ=%0d want=1", occupancy); else n_pass++;
        step(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 60, rand_phv(), $urandom_range(0, 99) < 45);
            if (occupancy !== exp_q.size()) errs++;
            if (empty !== (exp_q.size() == 0)) errs++;
            if (full !== (exp_q.size() == DEPTH)) errs++;
            if (nearly_full !== (exp_q.size() >= DEPTH - NF_MAR)) errs++;
            if (phase !== model_phase(exp_q.size())) errs++;
            if (drop_cnt !== exp_drop) errs++;
            if (exp_q.size() > 0 && phv_out !== exp_q[0]) errs++;
            if (parity_err !== 1'b0) errs++;
        end
        n_total++; if (errs != 0) $display("FAIL random_mix errors=%0d want=0", errs); else n_pass++;
        n_total++; if (drop_cnt !== exp_drop) $display("FAIL random_drop got=%0d want=%0d", drop_cnt, exp_drop); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] x;
        for (int i = 0; i < 5; i++) step(1'b1, rand_phv(), 1'b0);
        do_reset();
        n_total++; if (empty !== 1'b1 || occupancy !== 5'd0 || drop_cnt !== 32'd0) $display("FAIL midreset empty=%b occ=%0d drop=%0d want=1/0/0", empty, occupancy, drop_cnt); else n_pass++;
        n_total++; if (parity_err !== 1'b0 || phv_out !== '0) $display("FAIL midreset_out perr=%b out=%h want=0/0", parity_err, phv_out[127:0]); else n_pass++;
        x = rand_phv();
        step(1'b1, x, 1'b0);
        step(1'b1, rand_phv(), 1'b0);
        n_total++; if (phv_out !== x) $display("FAIL midreset_head got=%h want=%h", phv_out[127:0], x[127:0]); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_total++; if (phv_out !== exp_q[0] || occupancy !== 5'd1) $display("FAIL midreset_next got=%h want=%h", phv_out[127:0], exp_q[0][127:0]); else n_pass++;
    endtask

`ifdef RMT_PHV_BUF_PARITY_EN
    task automatic test_parity();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, rand_phv(), 1'b0);
        dut.g_seg[1].u_ram.mem[2][88] = ~dut.g_seg[1].u_ram.mem[2][88];
        exp_q[2][600] = ~exp_q[2][600];
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1);
        n_total++; if (parity_err !== 1'b0) $display("FAIL par_early got=%b want=0", parity_err); else n_pass++;
        n_total++; if (phv_out !== exp_q[0]) $display("FAIL par_data got=%h want=%h", phv_out[639:512], exp_q[0][639:512]); else n_pass++;
        step(1'b0, '0, 1'b1);
        n_total++; if (parity_err !== 1'b1) $display("FAIL par_set got=%b want=1", parity_err); else n_pass++;
        step(1'b0, '0, 1'b1);
        step(1'b1, rand_phv(), 1'b0);
        n_total++; if (parity_err !== 1'b1) $display("FAIL par_sticky got=%b want=1", parity_err); else n_pass++;
        do_reset();
        n_total++; if (parity_err !== 1'b0 || empty !== 1'b1) $display("FAIL par_reset perr=%b empty=%b want=0/1", parity_err, empty); else n_pass++;
    endtask
`endif

    initial begin
        n_pass   = 0;
        n_total  = 0;
        exp_drop = 0;
        test_reset();
        test_single();
        test_fill();
        test_overflow();
        test_full_rw();
        test_wrap();
        test_random();
        test_reset_mid();
`ifdef RMT_PHV_BUF_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
